nvdla_rws64_fifo_ctrl: RTL and testbench

Valid/ready FIFO controller that drives a 64-entry x 116-bit two-port register-file RAM. The RAM has a registered read address and a combinational read-data output. The controller owns the RAM's write port (address, enable, data) and read port (address, enable), and presents the stored entries as an in-order valid/ready stream. It is the writer/reader client that sits between an NVDLA producer/consumer pair and the RAM macro, so the RAM needs no flow-control logic of its own.

---
 rtl/nvdla_rws64_fifo_ctrl.sv | 109 ++++++++++
 tb/tb_nvdla_rws64_fifo_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_rws64_fifo_ctrl.sv
// Valid/ready FIFO controller for a 64x116 two-port RAM with registered read address.
// Optional peak-occupancy register enabled by defining NVDLA_RWS_FIFO_PEAK_EN.
module nvdla_rws64_fifo_ctrl #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 116
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [5:0]       ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [5:0]       ram_ra,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic [31:0]      ram_pwrbus_ram_pd,
    output logic [6:0]       fifo_count,
    output logic [6:0]       fifo_peak
);

    localparam logic [6:0] FULL = 7'(DEPTH);

    logic [5:0] wr_ptr_q, wr_ptr_d;
    logic [5:0] rd_ptr_q, rd_ptr_d;
    logic [6:0] count_q, count_d;
    logic [6:0] unread_q, unread_d;
    logic       dout_vld_q, dout_vld_d;
    logic       push, fetch, pop;

    assign wr_prdy = (count_q != FULL);
    assign push    = wr_pvld & wr_prdy;
    // A fetch may only replace the presented entry when it is leaving or absent.
    assign fetch   = (unread_q != 7'd0) & (~dout_vld_q | rd_prdy);
    assign pop     = dout_vld_q & rd_prdy;

    assign ram_we = push;
    assign ram_wa = wr_ptr_q;
    assign ram_di = wr_pd;
    assign ram_re = fetch;
    assign ram_ra = rd_ptr_q;

    assign rd_pvld = dout_vld_q;
    assign rd_pd   = ram_dout;

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
    assign fifo_count        = count_q;

    always_comb begin
        wr_ptr_d   = push  ? wr_ptr_q + 6'd1 : wr_ptr_q;
        rd_ptr_d   = fetch ? rd_ptr_q + 6'd1 : rd_ptr_q;
        dout_vld_d = fetch ? 1'b1 : (rd_prdy ? 1'b0 : dout_vld_q);

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 7'd1;
            2'b01:   count_d = count_q - 7'd1;
            default: count_d = count_q;
        endcase

        // Slots are freed on pop, so unread only tracks entries not yet sent to the RAM read port.
        unread_d = unread_q;
        unique case ({push, fetch})
            2'b10:   unread_d = unread_q + 7'd1;
            2'b01:   unread_d = unread_q - 7'd1;
            default: unread_d = unread_q;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q   <= 6'd0;
            rd_ptr_q   <= 6'd0;
            count_q    <= 7'd0;
            unread_q   <= 7'd0;
            dout_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            unread_q   <= unread_d;
            dout_vld_q <= dout_vld_d;
        end
    end

`ifdef NVDLA_RWS_FIFO_PEAK_EN
    logic [6:0] peak_q, peak_d;

    assign peak_d = (count_q > peak_q) ? count_q : peak_q;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            peak_q <= 7'd0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign fifo_peak = peak_q;
`else
    assign fifo_peak = 7'd0;
`endif

endmodule

// File: tb/tb_nvdla_rws64_fifo_ctrl.sv
// Directed self-checking bench for nvdla_rws64_fifo_ctrl with a behavioural RAM model.
module tb_nvdla_rws64_fifo_ctrl;

    logic         clk;
    logic         rstn;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [115:0] wr_pd;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [115:0] rd_pd;
    logic         ram_we;
    logic [5:0]   ram_wa;
    logic [115:0] ram_di;
    logic         ram_re;
    logic [5:0]   ram_ra;
    logic [115:0] ram_dout;
    logic [31:0]  pwrbus;
    logic [31:0]  ram_pwrbus;
    logic [6:0]   fifo_count;
    logic [6:0]   fifo_peak;

    int vectors = 0;
    int fails   = 0;

    logic [115:0] mem [64];
    logic [5:0]   raQ;

    nvdla_rws64_fifo_ctrl dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .ram_we            (ram_we),
        .ram_wa            (ram_wa),
        .ram_di            (ram_di),
        .ram_re            (ram_re),
        .ram_ra            (ram_ra),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus),
        .ram_pwrbus_ram_pd (ram_pwrbus),
        .fifo_count        (fifo_count),
        .fifo_peak         (fifo_peak)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM macro model: write and read-address capture on the rising edge, combinational read data.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        raQ = '0;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) raQ <= ram_ra;
    end

    assign ram_dout = mem[raQ];

    task automatic checkOutput(input string tag, input logic [115:0] observed, input logic [115:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pvld, input logic [115:0] pd, input logic prdy);
        wr_pvld = pvld;
        wr_pd   = pd;
        rd_prdy = prdy;
        #1;
    endtask

    logic [115:0] q [$];
    logic [115:0] expData;
    logic [5:0]   expWa;
    logic [5:0]   expRa;
    int           reCount;
    int           sent;
    int           got;
    int           modelCount;
    int           cyc;
    logic [6:0]   expPeak;

    initial begin
        rstn    = 1'b0;
        wr_pvld = 1'b0;
        wr_pd   = '0;
        rd_prdy = 1'b0;
        pwrbus  = 32'hDEAD_BEEF;
        #2;

        // Reset state
        checkOutput("rst_wr_prdy", wr_prdy, 1);
        checkOutput("rst_rd_pvld", rd_pvld, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_re", ram_re, 0);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_peak", fifo_peak, 0);
        checkOutput("pwrbus", ram_pwrbus, 32'hDEAD_BEEF);
        tick();
        rstn = 1'b1;
        tick();

        // Single entry, two-cycle latency
        applyStimulus(1'b1, 116'hA5, 1'b1);
        checkOutput("single_we", ram_we, 1);
        checkOutput("single_wa", ram_wa, 0);
        checkOutput("single_di", ram_di, 116'hA5);
        checkOutput("single_re0", ram_re, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_re1", ram_re, 1);
        checkOutput("single_ra1", ram_ra, 0);
        checkOutput("single_pvld1", rd_pvld, 0);
        checkOutput("single_cnt1", fifo_count, 1);
        tick();
        #1;
        checkOutput("single_pvld2", rd_pvld, 1);
        checkOutput("single_pd2", rd_pd, 116'hA5);
        checkOutput("single_re2", ram_re, 0);
        tick();
        #1;
        checkOutput("single_pvld3", rd_pvld, 0);
        checkOutput("single_cnt3", fifo_count, 0);

        // Fill 64 entries with the consumer stalled
        reCount = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 116'(i), 1'b0);
            if (ram_re) reCount++;
            tick();
        end
        applyStimulus(1'b1, 116'h99, 1'b0);
        checkOutput("full_cnt", fifo_count, 64);
        checkOutput("full_prdy", wr_prdy, 0);
        checkOutput("full_we", ram_we, 0);
        checkOutput("full_re", ram_re, 0);
        checkOutput("full_pvld", rd_pvld, 1);
        checkOutput("full_pd", rd_pd, 0);
        tick();
        #1;
        checkOutput("full_cnt65", fifo_count, 64);
        checkOutput("full_recount", reCount, 1);

        // Drain in order without bubbles
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            checkOutput("drain_pvld", rd_pvld, 1);
            checkOutput("drain_pd", rd_pd, 116'(i));
            tick();
            #1;
        end
        checkOutput("drain_pvld_end", rd_pvld, 0);
        checkOutput("drain_cnt_end", fifo_count, 0);

        // Wrap-around: 200 entries, consumer ready every other cycle; pointers now at 1
        expWa = 6'd1;
        expRa = 6'd1;
        sent = 0;
        got = 0;
        modelCount = 0;
        cyc = 0;
        while (got < 200 && cyc < 3000) begin
            applyStimulus(sent < 200, 116'(1000 + sent), cyc[0]);
            checkOutput("wrap_prdy", wr_prdy, modelCount != 64);
            if (ram_we) begin
                checkOutput("wrap_wa", ram_wa, expWa);
                expWa = expWa + 6'd1;
            end
            if (ram_re) begin
                checkOutput("wrap_ra", ram_ra, expRa);
                expRa = expRa + 6'd1;
            end
            if (wr_pvld && wr_prdy) begin
                q.push_back(116'(1000 + sent));
                sent++;
                modelCount++;
            end
            if (rd_pvld && rd_prdy) begin
                if (q.size() == 0) begin
                    checkOutput("wrap_underflow", rd_pvld, 0);
                end else begin
                    expData = q.pop_front();
                    checkOutput("wrap_data", rd_pd, expData);
                end
                got++;
                modelCount--;
            end
            tick();
            cyc++;
        end
        checkOutput("wrap_got", got, 200);
        checkOutput("wrap_cnt", fifo_count, 0);
        checkOutput("wrap_wa_end", expWa, 6'd9);

        // Stall: presented entry held while pushes continue
        applyStimulus(1'b1, 116'h55, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 116'(256 + k), 1'b0);
            checkOutput("stall_pvld", rd_pvld, 1);
            checkOutput("stall_pd", rd_pd, 116'h55);
            checkOutput("stall_re", ram_re, 0);
            tick();
        end
        checkOutput("stall_cnt", fifo_count, 11);

        // Reset mid-stream at count 30
        for (int k = 0; k < 19; k++) begin
            applyStimulus(1'b1, 116'(512 + k), 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("mid_cnt30", fifo_count, 30);
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_pvld", rd_pvld, 0);
        checkOutput("mid_rst_cnt", fifo_count, 0);
        checkOutput("mid_rst_prdy", wr_prdy, 1);
        tick();
        rstn = 1'b1;
        tick();
        applyStimulus(1'b1, 116'hBEEF, 1'b1);
        checkOutput("mid_wa", ram_wa, 0);
        checkOutput("mid_we", ram_we, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("mid_re", ram_re, 1);
        checkOutput("mid_ra", ram_ra, 0);
        tick();
        #1;
        checkOutput("mid_pvld", rd_pvld, 1);
        checkOutput("mid_pd", rd_pd, 116'hBEEF);
        tick();
        #1;
        checkOutput("mid_cnt_end", fifo_count, 0);

        // Peak: fill to 40 then drain
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 116'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("peak_cnt40", fifo_count, 40);
        cyc = 0;
        while (fifo_count != 7'd0 && cyc < 200) begin
            tick();
            cyc++;
        end
        tick();
        #1;
        checkOutput("peak_drained", fifo_count, 0);
`ifdef NVDLA_RWS_FIFO_PEAK_EN
        expPeak = 7'd40;
`else
        expPeak = 7'd0;
`endif
        checkOutput("peak_value", fifo_peak, expPeak);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
